// File: rtl/picosoc_sram_ctrl_if.sv
// PicoSoC native memory bus (picorv32 mem_* handshake).
// master: CPU / address decoder side, drives the request.
// slave : memory controller side, returns mem_ready and mem_rdata.
//   mem_valid  request, held until mem_ready is sampled high
//   mem_ready  one-cycle completion pulse
//   mem_addr   byte address
//   mem_wdata  write data
//   mem_wstrb  byte strobes, 4'h0 = read
//   mem_rdata  read data, valid while mem_ready = 1
interface picosoc_sram_ctrl_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid,
    output mem_addr,
    output mem_wdata,
    output mem_wstrb,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_valid,
    input  mem_addr,
    input  mem_wdata,
    input  mem_wstrb,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/picosoc_sram_ctrl.sv
// Bus-side initiator for a 512x32 byte-writable SRAM macro.
// Turns mem_valid/mem_ready transactions into registered active-low
// chip-enable / byte-write-enable cycles and returns read data. With
// CLEAR_ON_RESET = 1 all 512 words are zero-filled before requests are taken.
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   bus           native memory bus (slave side)
//   sram_cen      active-low chip enable
//   sram_wen      active-low per-byte write enables
//   sram_a        word address
//   sram_d        write data
//   sram_q        read data, valid the cycle after a read edge
//   init_done     high once requests are accepted
module picosoc_sram_ctrl #(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                      clk,
  input  logic                      resetn,
  picosoc_sram_ctrl_if.slave        bus,
  output logic                      sram_cen,
  output logic [3:0]                sram_wen,
  output logic [8:0]                sram_a,
  output logic [31:0]               sram_d,
  input  logic [31:0]               sram_q,
  output logic                      init_done
);

  typedef enum logic [2:0] {StClear, StIdle, StAcc, StRcap, StDone} state_e;

  localparam state_e ResetState = CLEAR_ON_RESET ? StClear : StIdle;

  state_e      state_q, state_d;
  logic [8:0]  k_q, k_d;
  logic        mem_ready_q, mem_ready_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        sram_cen_q, sram_cen_d;
  logic [3:0]  sram_wen_q, sram_wen_d;
  logic [8:0]  sram_a_q, sram_a_d;
  logic [31:0] sram_d_q, sram_d_d;
  logic        init_done_q, init_done_d;

  // Word 511 has been presented to the macro; it is written on this edge.
  logic clear_last;
  assign clear_last = !sram_cen_q && (sram_a_q == 9'h1FF);

  // Upstream decoding owns the remaining address bits.
  logic unused_addr;
  assign unused_addr = ^{bus.mem_addr[31:11], bus.mem_addr[1:0]};

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ResetState;
      k_q         <= 9'd0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= 32'd0;
      sram_cen_q  <= 1'b1;
      sram_wen_q  <= 4'hF;
      sram_a_q    <= 9'd0;
      sram_d_q    <= 32'd0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      mem_ready_q <= mem_ready_d;
      mem_rdata_q <= mem_rdata_d;
      sram_cen_q  <= sram_cen_d;
      sram_wen_q  <= sram_wen_d;
      sram_a_q    <= sram_a_d;
      sram_d_q    <= sram_d_d;
      init_done_q <= init_done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StClear: if (clear_last) state_d = StIdle;
      StIdle:  if (bus.mem_valid) state_d = StAcc;
      StAcc:   state_d = (sram_wen_q != 4'hF) ? StDone : StRcap;
      StRcap:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Registered output values
  always_comb begin
    k_d         = k_q;
    mem_ready_d = 1'b0;
    mem_rdata_d = mem_rdata_q;
    sram_cen_d  = 1'b1;
    sram_wen_d  = 4'hF;
    sram_a_d    = sram_a_q;
    sram_d_d    = sram_d_q;
    init_done_d = init_done_q;
    unique case (state_q)
      StClear: begin
        if (clear_last) begin
          init_done_d = 1'b1;
        end else begin
          sram_cen_d = 1'b0;
          sram_wen_d = 4'h0;
          sram_a_d   = k_q;
          sram_d_d   = 32'd0;
          k_d        = k_q + 9'd1;
        end
      end
      StIdle: begin
        init_done_d = 1'b1;
        if (bus.mem_valid) begin
          sram_cen_d = 1'b0;
          sram_a_d   = bus.mem_addr[10:2];
          sram_d_d   = bus.mem_wdata;
          sram_wen_d = ~bus.mem_wstrb;
        end
      end
      StAcc: begin
        // Writes complete here; reads wait one more cycle for sram_q.
        if (sram_wen_q != 4'hF) mem_ready_d = 1'b1;
      end
      StRcap: begin
        mem_rdata_d = sram_q;
        mem_ready_d = 1'b1;
      end
      StDone: begin
      end
      default: begin
      end
    endcase
  end

  assign bus.mem_ready = mem_ready_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign sram_cen      = sram_cen_q;
  assign sram_wen      = sram_wen_q;
  assign sram_a        = sram_a_q;
  assign sram_d        = sram_d_q;
  assign init_done     = init_done_q;

endmodule

// File: tb/tb_picosoc_sram_ctrl.sv
// Self-checking bench for picosoc_sram_ctrl: behavioural SRAM macro plus a
// word-array reference model of memory contents, directed and random traffic.
module tb_picosoc_sram_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        sram_cen;
  logic [3:0]  sram_wen;
  logic [8:0]  sram_a;
  logic [31:0] sram_d;
  logic [31:0] sram_q;
  logic        init_done;
  logic        preload = 1'b1;

  always #5 clk = ~clk;

  picosoc_sram_ctrl_if bus ();

  picosoc_sram_ctrl #(.CLEAR_ON_RESET(1'b1)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .sram_cen  (sram_cen),
    .sram_wen  (sram_wen),
    .sram_a    (sram_a),
    .sram_d    (sram_d),
    .sram_q    (sram_q),
    .init_done (init_done)
  );

  // Behavioural SRAM macro; q is garbage except the cycle after a read edge.
  logic [31:0] sram_mem [512];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 512; i++) sram_mem[i] <= 32'hDEADBEEF;
      sram_q <= $urandom;
    end else if (sram_cen == 1'b0) begin
      for (int b = 0; b < 4; b++)
        if (!sram_wen[b]) sram_mem[sram_a][b*8 +: 8] <= sram_d[b*8 +: 8];
      sram_q <= (sram_wen == 4'hF) ? sram_mem[sram_a] : $urandom;
    end else begin
      sram_q <= $urandom;
    end
  end

  logic [31:0] ref_mem [512];
  logic [31:0] last_rdata;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edge 1 is the first edge after reset release.
  task automatic run_clear(input bit pending);
    int bad = 0;
    int ready_seen = 0;
    int lat = 0;
    for (int e = 1; e <= 513; e++) begin
      tick();
      if (e <= 512)
        if (sram_cen !== 1'b0 || sram_wen !== 4'h0 || sram_a !== 9'(e - 1) || sram_d !== 32'd0)
          bad++;
      if (bus.mem_ready !== 1'b0) ready_seen++;
      if (e == 512) check_eq("init_done_before_513", 32'(init_done), 32'd0);
      if (pending && e == 5) begin
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h0000_01FC;
        bus.mem_wstrb = 4'h0;
        bus.mem_wdata = $urandom;
      end
    end
    check_eq("clear_sequence_errors", bad, 0);
    check_eq("ready_during_clear", ready_seen, 0);
    check_eq("init_done_after_513", 32'(init_done), 32'd1);
    check_eq("cen_after_clear", 32'(sram_cen), 32'd1);
    check_eq("wen_after_clear", 32'(sram_wen), 32'hF);
    for (int i = 0; i < 512; i++) ref_mem[i] = 32'd0;
    if (pending) begin
      do begin
        tick();
        lat++;
      end while (bus.mem_ready !== 1'b1 && lat < 12);
      check_eq("pending_latency", lat, 3);
      check_eq("pending_rdata", bus.mem_rdata, 32'd0);
      last_rdata = 32'd0;
      bus.mem_valid = 1'b0;
      tick();
    end
  endtask

  // Returns in the cycle where mem_ready is high. b2b: the previous request's
  // valid stayed high through its DONE cycle, costing one extra cycle.
  task automatic do_txn(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input bit b2b);
    int         lat = 0;
    int         cen_lo = 0;
    int         exp_lat;
    logic [8:0] idx;
    logic [3:0] wen_exp;
    idx     = addr[10:2];
    wen_exp = ~strb;
    exp_lat = ((strb != 4'h0) ? 2 : 3) + (b2b ? 1 : 0);
    bus.mem_valid = 1'b1;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    bus.mem_wstrb = strb;
    do begin
      tick();
      lat++;
      if (sram_cen === 1'b0) begin
        cen_lo++;
        check_eq("sram_a", 32'(sram_a), 32'(idx));
        check_eq("sram_wen", 32'(sram_wen), 32'(wen_exp));
        if (strb != 4'h0) check_eq("sram_d", sram_d, wdata);
      end
    end while (bus.mem_ready !== 1'b1 && lat < 12);
    check_eq("latency", lat, exp_lat);
    check_eq("cen_pulses", cen_lo, 1);
    if (strb != 4'h0) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) ref_mem[idx][b*8 +: 8] = wdata[b*8 +: 8];
      check_eq("rdata_hold_on_write", bus.mem_rdata, last_rdata);
    end else begin
      check_eq("rdata", bus.mem_rdata, ref_mem[idx]);
      last_rdata = ref_mem[idx];
    end
    bus.mem_valid = 1'b0;
  endtask

  initial begin
    int  nonzero;
    int  gap;
    bit  b2b;
    logic [3:0] strb;
    bus.mem_valid = 1'b0;
    bus.mem_addr  = 32'd0;
    bus.mem_wdata = 32'd0;
    bus.mem_wstrb = 4'h0;
    last_rdata    = 32'd0;

    #1 resetn = 1'b0;
    #1;
    check_eq("rst_mem_ready", 32'(bus.mem_ready), 32'd0);
    check_eq("rst_mem_rdata", bus.mem_rdata, 32'd0);
    check_eq("rst_sram_cen", 32'(sram_cen), 32'd1);
    check_eq("rst_sram_wen", 32'(sram_wen), 32'hF);
    check_eq("rst_sram_a", 32'(sram_a), 32'd0);
    check_eq("rst_sram_d", sram_d, 32'd0);
    check_eq("rst_init_done", 32'(init_done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    preload = 1'b0;
    resetn  = 1'b1;

    // Clear with a read of 0x1FC pending from cycle 5.
    run_clear(1'b1);
    nonzero = 0;
    for (int i = 0; i < 512; i++) if (sram_mem[i] !== 32'd0) nonzero++;
    check_eq("nonzero_after_clear", nonzero, 0);

    // Directed traffic.
    do_txn(32'h0000_0010, 32'h1234_5678, 4'hF, 1'b0); tick();
    do_txn(32'h0000_0010, 32'd0, 4'h0, 1'b0);
    check_eq("rd_full_word", bus.mem_rdata, 32'h1234_5678); tick();
    do_txn(32'h0000_0020, 32'h1122_3344, 4'hF, 1'b0); tick();
    do_txn(32'h0000_0020, 32'hAABB_CCDD, 4'b0101, 1'b0); tick();
    do_txn(32'h0000_0020, 32'd0, 4'h0, 1'b0);
    check_eq("rd_partial", bus.mem_rdata, 32'h11BB_33DD); tick();
    do_txn(32'h0000_0810, 32'd0, 4'h0, 1'b0);
    check_eq("rd_alias", bus.mem_rdata, 32'h1234_5678); tick();

    // Reset while a read sits in ACC.
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 32'h0000_0010;
    bus.mem_wstrb = 4'h0;
    tick();
    check_eq("acc_cen_low", 32'(sram_cen), 32'd0);
    #2 resetn = 1'b0;
    #1;
    check_eq("midrst_cen", 32'(sram_cen), 32'd1);
    check_eq("midrst_ready", 32'(bus.mem_ready), 32'd0);
    check_eq("midrst_wen", 32'(sram_wen), 32'hF);
    check_eq("midrst_init_done", 32'(init_done), 32'd0);
    check_eq("midrst_rdata", bus.mem_rdata, 32'd0);
    bus.mem_valid = 1'b0;
    last_rdata    = 32'd0;
    @(negedge clk);
    resetn = 1'b1;
    run_clear(1'b0);
    do_txn(32'h0000_0010, 32'd0, 4'h0, 1'b0); tick();

    // Random traffic against the reference model.
    b2b = 1'b0;
    for (int i = 0; i < 60; i++) begin
      strb = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      do_txn($urandom, $urandom, strb, b2b);
      gap = $urandom_range(0, 2);
      repeat (gap) tick();
      b2b = (gap == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
